// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_conv_arbiter
// Purpose  : Two-requester arbiter in front of a shared bit-serial
//            double-dabble binary-to-BCD converter.
//            Tie-break: round robin if BCD_ARB_ROUND_ROBIN_EN is defined,
//            otherwise fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_conv_arbiter #(
  parameter int BIN_W  = 11,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [BIN_W-1:0]      req0_bin,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [BIN_W-1:0]      req1_bin,
  output logic                  req1_ready,
  output logic                  res_valid,
  output logic                  res_id,
  output logic [DIGITS*4-1:0]   res_bcd,
  output logic                  busy
);

  localparam int ACC_W = DIGITS * 4;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic               owner_q, owner_d;
  logic               last_id_q, last_id_d;
  logic [ACC_W-1:0]   res_bcd_q, res_bcd_d;
  logic               res_id_q, res_id_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  logic               grant;
  logic               accept;
  logic [ACC_W-1:0]   adj;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef BCD_ARB_ROUND_ROBIN_EN
      grant = ~last_id_q;
`else
      grant = 1'b0;
`endif
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && !grant;
  assign req1_ready = (state_q == IDLE) && grant;
  assign accept     = grant ? req1_ready && req1_valid : req0_ready && req0_valid;

  // Per-digit add-3 correction; digits never carry into each other.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign adj[g*4 +: 4] = (acc_q[g*4 +: 4] >= 4'd5) ? acc_q[g*4 +: 4] + 4'd3
                                                      : acc_q[g*4 +: 4];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    shreg_d     = shreg_q;
    owner_d     = owner_q;
    last_id_d   = last_id_q;
    res_bcd_d   = res_bcd_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = grant ? req1_bin : req0_bin;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          owner_d = grant;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = {adj[ACC_W-2:0], shreg_q[BIN_W-1]};
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        res_bcd_d   = acc_q;
        res_id_d    = owner_q;
        res_valid_d = 1'b1;
        last_id_d   = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      shreg_q     <= '0;
      owner_q     <= 1'b0;
      last_id_q   <= 1'b1;
      res_bcd_q   <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      shreg_q     <= shreg_d;
      owner_q     <= owner_d;
      last_id_q   <= last_id_d;
      res_bcd_q   <= res_bcd_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_bcd   = res_bcd_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_conv_arbiter
// Purpose  : Self-checking bench for bcd_conv_arbiter (vector table, directed
//            corner sequences, randomized run against a decimal-digit model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_arbiter;

`ifdef BCD_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [10:0] req0_bin, req1_bin;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_id;
  logic [15:0] res_bcd;
  logic        busy;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.BIN_W(11), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_bin(req0_bin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_bin(req1_bin), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_bcd(res_bcd), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal digit extraction.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  typedef struct { bit id; int val; logic [15:0] exp_bcd; } vec_t;
  typedef struct { bit id; int val; } acc_t;

  vec_t        vecs[6];
  acc_t        q[$];
  acc_t        e;
  logic [15:0] bcd;
  bit          rid, ok;
  int          lat;
  int          tcyc[4];
  bit          tid[4];
  logic [15:0] tbcd[4];
  int          got, cyc, results;
  bit          r1seen, seen, last_m, a0, a1;

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_bin = '0; req1_bin = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_one(input bit id, input logic [10:0] val,
                         output logic [15:0] o_bcd, output bit o_id,
                         output int o_lat, output bit o_ok);
    int n;
    o_ok = 1'b0; o_bcd = '0; o_id = 1'b0; o_lat = 0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_bin = val; end
    else    begin req0_valid = 1'b1; req0_bin = val; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    while (o_lat < 40) begin
      @(negedge clk);
      o_lat++;
      if (res_valid) break;
    end
    if (res_valid) begin
      o_ok  = 1'b1;
      o_bcd = res_bcd;
      o_id  = res_id;
      o_lat = o_lat - 1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 2047, 16'h2047};
    vecs[1] = '{1'b1, 0,    16'h0000};
    vecs[2] = '{1'b1, 1,    16'h0001};
    vecs[3] = '{1'b1, 1000, 16'h1000};
    vecs[4] = '{1'b0, 9,    16'h0009};
    vecs[5] = '{1'b1, 1999, 16'h1999};

    // Reset values while reset is held
    req0_valid = 1'b0; req1_valid = 1'b0; req0_bin = '0; req1_bin = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_bcd", res_bcd, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_req1_ready", req1_ready, 0);
    do_reset();

    // Single-requester vector table
    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].id, 11'(vecs[i].val), bcd, rid, lat, ok);
      chk("vec_done", ok, 1);
      chk("vec_bcd", bcd, vecs[i].exp_bcd);
      chk("vec_id", rid, vecs[i].id);
      chk("vec_latency", lat, 12);
    end

    // Reset in the middle of a conversion
    @(negedge clk);
    req0_valid = 1'b1; req0_bin = 11'd555;
    #1;
    chk("mid_ready", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_req0_ready_low", req0_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_bcd", res_bcd, 0);
    chk("mid_rst_res_id", res_id, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("mid_no_res_valid", seen, 0);
    run_one(1'b0, 11'd999, bcd, rid, lat, ok);
    chk("post_rst_done", ok, 1);
    chk("post_rst_bcd", bcd, 16'h0999);
    chk("post_rst_id", rid, 0);

    // Both requesters valid continuously
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_bin = 11'd123;
    req1_valid = 1'b1; req1_bin = 11'd456;
    got = 0; cyc = 0; r1seen = 1'b0;
    for (int k = 0; k < 4; k++) begin tcyc[k] = 0; tid[k] = 1'b0; tbcd[k] = 'x; end
    while (got < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req1_ready) r1seen = 1'b1;
      if (res_valid) begin
        tid[got] = res_id; tbcd[got] = res_bcd; tcyc[got] = cyc;
        got++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_count", got, 4);
    for (int k = 0; k < 4; k++) begin
      bit exp_id;
      exp_id = RR ? 1'(k % 2) : 1'b0;
      chk("tie_id", tid[k], exp_id);
      chk("tie_bcd", tbcd[k], exp_id ? 16'h0456 : 16'h0123);
      if (k > 0) chk("tie_gap", tcyc[k] - tcyc[k-1], 13);
    end
    if (!RR) chk("tie_req1_ready_never", r1seen, 0);

    // Randomized traffic against the model
    do_reset();
    last_m = 1'b1; results = 0; cyc = 0;
    q.delete();
    while (results < 500 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        if (q.size() == 0) begin
          chk("rand_spurious_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rand_bcd", res_bcd, to_bcd(e.val));
          chk("rand_id", res_id, e.id);
          last_m = e.id;
        end
        results++;
      end
      chk("rand_one_ready", req0_ready && req1_ready, 0);
      if (req0_valid && req1_valid && (req0_ready || req1_ready))
        chk("rand_tie_grant", req1_ready, RR ? !last_m : 1'b0);
      if (!busy && (req0_valid ^ req1_valid))
        chk("rand_single_grant", req1_valid ? req1_ready : req0_ready, 1);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) q.push_back('{1'b0, int'(req0_bin)});
      if (a1) q.push_back('{1'b1, int'(req1_bin)});
      @(posedge clk);
      #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(1, 0) == 1) begin
        req0_valid = 1'b1; req0_bin = 11'($urandom_range(2047, 0));
      end
      if (!req1_valid && $urandom_range(1, 0) == 1) begin
        req1_valid = 1'b1; req1_bin = 11'($urandom_range(2047, 0));
      end
    end
    chk("rand_all_done", results >= 500, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
